// File: rtl/ex_seq_pkg.sv
// Shared opcode constants, FSM state type and op classification for the issue sequencer.
package ex_seq_pkg;

    localparam int unsigned OP_W   = 5;
    localparam int unsigned FLAG_W = 4;

    localparam logic [OP_W-1:0] OP_LD = 5'b10100;
    localparam logic [OP_W-1:0] OP_ST = 5'b10101;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    // Loads and stores need the extra memory wait; everything else, including undefined codes, is ALU-class.
    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/ex_seq_fifo.sv
// Instruction FIFO: synchronous push/pop, async active-low flush, combinational head read.
module ex_seq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 29
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage needs no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ex_issue_seq.sv
// Issue sequencer: buffers decoded instructions, issues one at a time to the execution unit,
// waits ALU or memory latency, and holds the captured result until the consumer accepts it.
module ex_issue_seq
    import ex_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W-1:0]          in_op,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     ex_valid,
    output logic [OP_W-1:0]          ex_op,
    output logic [WIDTH-1:0]         ex_a,
    output logic [WIDTH-1:0]         ex_b,
    output logic [WIDTH-1:0]         ex_data_in,
    input  logic [WIDTH-1:0]         ex_ans,
    input  logic [FLAG_W-1:0]        ex_flag,
    input  logic [WIDTH-1:0]         ex_dm,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_ans,
    output logic [FLAG_W-1:0]        res_flag,
    output logic [WIDTH-1:0]         res_dm,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int unsigned ENTRY_W = OP_W + 3 * WIDTH;
    localparam int unsigned WCNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t             state;
    logic [WCNT_W-1:0]  wait_cnt;
    logic [ENTRY_W-1:0] head;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;

    // No push-through when full: a pop in the same cycle does not open a slot.
    assign in_ready = reset && !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_IDLE) && !empty && (!res_valid || res_ready);
    assign busy     = (state != S_IDLE) || !empty;

    ex_seq_fifo #(
        .DEPTH (DEPTH),
        .DW    (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({in_op, in_a, in_b, in_data}),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    // Sequencer FSM with registered issue and result outputs; a CAPTURE reload overrides a same-cycle drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            ex_valid   <= 1'b0;
            ex_op      <= '0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_data_in <= '0;
            res_valid  <= 1'b0;
            res_ans    <= '0;
            res_flag   <= '0;
            res_dm     <= '0;
        end else begin
            ex_valid <= 1'b0;
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {ex_op, ex_a, ex_b, ex_data_in} <= head;
                        ex_valid <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (is_mem_op(ex_op)) begin
                        wait_cnt <= WCNT_W'(MEM_LAT - 1);
                        state    <= S_WAIT;
                    end else begin
                        state <= S_CAPTURE;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= S_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - WCNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    res_valid <= 1'b1;
                    res_ans   <= ex_ans;
                    res_flag  <= ex_flag;
                    res_dm    <= ex_dm;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_issue_seq.sv
// Directed bench for ex_issue_seq with a trivial execution-unit model and immediate-assertion checks.
module tb_ex_issue_seq;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [7:0] in_data;
    logic       ex_valid;
    logic [4:0] ex_op;
    logic [7:0] ex_a;
    logic [7:0] ex_b;
    logic [7:0] ex_data_in;
    logic [7:0] ex_ans;
    logic [3:0] ex_flag;
    logic [7:0] ex_dm;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_ans;
    logic [3:0] res_flag;
    logic [7:0] res_dm;
    logic [2:0] fifo_count;
    logic       busy;

    logic       m_tag;
    logic [7:0] m_ans;
    logic [3:0] m_flag;
    logic [7:0] m_dm;

    int checks;
    int errors;

    ex_issue_seq #(
        .WIDTH   (8),
        .DEPTH   (4),
        .MEM_LAT (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_data    (in_data),
        .ex_valid   (ex_valid),
        .ex_op      (ex_op),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .ex_data_in (ex_data_in),
        .ex_ans     (ex_ans),
        .ex_flag    (ex_flag),
        .ex_dm      (ex_dm),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_ans    (res_ans),
        .res_flag   (res_flag),
        .res_dm     (res_dm),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    // Execution-unit model: optionally tags the answer with operand A.
    assign ex_ans  = m_tag ? ex_a : m_ans;
    assign ex_flag = m_flag;
    assign ex_dm   = m_dm;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int acc;
        int pulses;
        int nres;
        int stale;
        logic will_push;

        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_data   = '0;
        res_ready = 1'b0;
        m_tag     = 1'b0;
        m_ans     = '0;
        m_flag    = '0;
        m_dm      = '0;

        // 1: reset values and release
        tick(3);
        chk("rst_in_ready",   32'(in_ready),   32'd0);
        chk("rst_ex_valid",   32'(ex_valid),   32'd0);
        chk("rst_res_valid",  32'(res_valid),  32'd0);
        chk("rst_ex_op",      32'(ex_op),      32'd0);
        chk("rst_res_ans",    32'(res_ans),    32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready",   32'(in_ready),   32'd1);
        chk("rel_fifo_count", 32'(fifo_count), 32'd0);
        chk("rel_busy",       32'(busy),       32'd0);

        // 2: single ALU op
        tick(1);
        res_ready = 1'b1;
        m_ans     = 8'h00;
        m_flag    = 4'b0011;
        in_valid  = 1'b1;
        in_op     = 5'b00000;
        in_a      = 8'd64;
        in_b      = 8'd192;
        in_data   = 8'd8;
        tick(1);
        in_valid = 1'b0;
        chk("alu_count_push", 32'(fifo_count), 32'd1);
        chk("alu_noissue_yet", 32'(ex_valid), 32'd0);
        tick(1);
        chk("alu_ex_valid",   32'(ex_valid),   32'd1);
        chk("alu_ex_op",      32'(ex_op),      32'd0);
        chk("alu_ex_a",       32'(ex_a),       32'd64);
        chk("alu_ex_b",       32'(ex_b),       32'd192);
        chk("alu_ex_data",    32'(ex_data_in), 32'd8);
        chk("alu_count_pop",  32'(fifo_count), 32'd0);
        tick(1);
        chk("alu_pulse_end",  32'(ex_valid),   32'd0);
        chk("alu_res_early",  32'(res_valid),  32'd0);
        chk("alu_ex_a_held",  32'(ex_a),       32'd64);
        tick(1);
        chk("alu_res_valid",  32'(res_valid),  32'd1);
        chk("alu_res_ans",    32'(res_ans),    32'h00);
        chk("alu_res_flag",   32'(res_flag),   32'b0011);
        tick(1);
        chk("alu_res_drain",  32'(res_valid),  32'd0);
        chk("alu_busy_idle",  32'(busy),       32'd0);
        chk("alu_ex_a_last",  32'(ex_a),       32'd64);

        // 3: memory op, MEM_LAT=2
        m_ans    = 8'h11;
        m_flag   = 4'b0000;
        m_dm     = 8'h5A;
        in_valid = 1'b1;
        in_op    = 5'b10100;
        in_a     = 8'd1;
        in_b     = 8'd2;
        in_data  = 8'd3;
        tick(1);
        in_valid = 1'b0;
        tick(1);
        chk("mem_ex_valid",   32'(ex_valid),   32'd1);
        chk("mem_ex_op",      32'(ex_op),      32'b10100);
        tick(1);
        chk("mem_wait1_res",  32'(res_valid),  32'd0);
        chk("mem_wait1_busy", 32'(busy),       32'd1);
        tick(1);
        chk("mem_wait2_res",  32'(res_valid),  32'd0);
        tick(1);
        chk("mem_capt_res",   32'(res_valid),  32'd0);
        chk("mem_capt_op",    32'(ex_op),      32'b10100);
        tick(1);
        chk("mem_res_valid",  32'(res_valid),  32'd1);
        chk("mem_res_dm",     32'(res_dm),     32'h5A);
        chk("mem_res_ans",    32'(res_ans),    32'h11);
        tick(1);
        chk("mem_res_drain",  32'(res_valid),  32'd0);

        // 4: backpressure fills the FIFO
        res_ready = 1'b0;
        m_tag     = 1'b1;
        in_op     = 5'b00000;
        in_a      = 8'd1;
        in_b      = 8'd0;
        in_data   = 8'd0;
        in_valid  = 1'b1;
        acc       = 0;
        pulses    = 0;
        for (int c = 0; c < 14; c++) begin
            will_push = in_valid && in_ready;
            tick(1);
            if (ex_valid) pulses++;
            if (will_push) begin
                acc++;
                in_a = 8'(acc + 1);
            end
        end
        chk("bp_accepted",    32'(acc),        32'd5);
        chk("bp_pulses",      32'(pulses),     32'd1);
        chk("bp_fifo_count",  32'(fifo_count), 32'd4);
        chk("bp_in_ready",    32'(in_ready),   32'd0);
        chk("bp_res_valid",   32'(res_valid),  32'd1);
        chk("bp_res_held",    32'(res_ans),    32'd1);
        in_valid = 1'b0;

        // 5: drain in program order
        res_ready = 1'b1;
        nres      = 0;
        for (int c = 0; c < 30; c++) begin
            if (res_valid) begin
                nres++;
                chk("order_res_ans", 32'(res_ans), 32'(nres));
            end
            tick(1);
        end
        chk("drain_count",      32'(nres),       32'd5);
        chk("drain_fifo_count", 32'(fifo_count), 32'd0);
        chk("drain_busy",       32'(busy),       32'd0);

        // 6: reset in WAIT with two ops queued
        m_tag    = 1'b0;
        m_dm     = 8'h77;
        in_valid = 1'b1;
        in_op    = 5'b10100;
        in_a     = 8'd9;
        tick(1);
        in_op = 5'b00000;
        in_a  = 8'd10;
        tick(1);
        in_a = 8'd11;
        tick(1);
        in_valid = 1'b0;
        chk("mid_fifo_count", 32'(fifo_count), 32'd2);
        chk("mid_busy",       32'(busy),       32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_ex_valid",   32'(ex_valid),   32'd0);
        chk("arst_res_valid",  32'(res_valid),  32'd0);
        chk("arst_fifo_count", 32'(fifo_count), 32'd0);
        chk("arst_in_ready",   32'(in_ready),   32'd0);
        chk("arst_busy",       32'(busy),       32'd0);
        tick(2);
        reset = 1'b1;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            if (ex_valid || res_valid) stale++;
        end
        chk("post_stale",      32'(stale),      32'd0);
        chk("post_fifo_count", 32'(fifo_count), 32'd0);
        chk("post_busy",       32'(busy),       32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
